// File: rtl/irq_ctrl_pkg.sv
// Shared constants, FSM states and cause encoding
// for the machine-mode interrupt controller.
package irq_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MSI_BIT  = 3;
    localparam int MTI_BIT  = 7;
    localparam int MEI_BIT  = 11;

    localparam logic [31:0] CODE_MSI  = 32'd3;
    localparam logic [31:0] CODE_MTI  = 32'd7;
    localparam logic [31:0] CODE_MEI  = 32'd11;
    localparam logic [31:0] CAUSE_IRQ = 32'h8000_0000;

    localparam logic [31:0] MSTATUS_MASK = 32'h0000_0088;
    localparam logic [31:0] MIE_MASK     = 32'h0000_0888;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        TRAP
    } state_t;

    // External beats software beats timer.
    function automatic logic [31:0] irq_cause(input logic [31:0] pend);
        logic [31:0] code;
        if (pend[MEI_BIT])
            code = CODE_MEI;
        else if (pend[MSI_BIT])
            code = CODE_MSI;
        else
            code = CODE_MTI;
        return CAUSE_IRQ | code;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// CSR access and trap handshake between the core
// and the interrupt controller.
interface irq_ctrl_if;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic        trap_ack;
    logic        mret;

    modport master (
        output csr_we, csr_addr, csr_wdata, trap_ack, mret,
        input  csr_rdata, trap_req, trap_cause
    );

    modport slave (
        input  csr_we, csr_addr, csr_wdata, trap_ack, mret,
        output csr_rdata, trap_req, trap_cause
    );
endinterface

// File: rtl/irq_ctrl_sync2.sv
// Two-flop synchronizer for an asynchronous level.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: mstatus/mie/mip
// and a request/ack/mret trap handshake.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter bit SYNC_EXT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       irq_timer,
    input  logic       irq_sw,
    input  logic       irq_ext,
    irq_ctrl_if.slave  bus
);
    logic        ext_s;
    logic [31:0] mstatus_q;
    logic [31:0] mie_q;
    logic [31:0] mip;
    logic [31:0] pend;
    logic        eligible;
    state_t      state_q;
    state_t      state_d;
    logic        take;
    logic        do_ack;
    logic        do_ret;
    logic        trap_req_q;
    logic [31:0] cause_q;

    generate
        if (SYNC_EXT) begin : g_sync
            sync2 u_sync (
                .clk (clk),
                .rst (rst),
                .d   (irq_ext),
                .q   (ext_s)
            );
        end else begin : g_nosync
            assign ext_s = irq_ext;
        end
    endgenerate

    always_comb begin
        mip          = '0;
        mip[MSI_BIT] = irq_sw;
        mip[MTI_BIT] = irq_timer;
        mip[MEI_BIT] = ext_s;
    end

    assign pend     = mip & mie_q;
    assign eligible = mstatus_q[MIE_BIT] && (pend != '0);

    always_comb begin
        case (bus.csr_addr)
            CSR_MSTATUS: bus.csr_rdata = mstatus_q;
            CSR_MIE:     bus.csr_rdata = mie_q;
            CSR_MIP:     bus.csr_rdata = mip;
            default:     bus.csr_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        do_ack  = 1'b0;
        do_ret  = 1'b0;
        unique case (state_q)
            IDLE: begin
                do_ret = bus.mret;
                if (eligible) begin
                    state_d = REQ;
                    take    = 1'b1;
                end
            end
            REQ: begin
                if (bus.trap_ack) begin
                    state_d = TRAP;
                    do_ack  = 1'b1;
                end
            end
            TRAP: begin
                if (bus.mret) begin
                    state_d = IDLE;
                    do_ret  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Trap entry/return overrides a coincident mstatus write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_q <= '0;
            mie_q     <= '0;
        end else begin
            if (bus.csr_we && bus.csr_addr == CSR_MIE)
                mie_q <= bus.csr_wdata & MIE_MASK;
            if (do_ack) begin
                mstatus_q[MPIE_BIT] <= mstatus_q[MIE_BIT];
                mstatus_q[MIE_BIT]  <= 1'b0;
            end else if (do_ret) begin
                mstatus_q[MIE_BIT]  <= mstatus_q[MPIE_BIT];
                mstatus_q[MPIE_BIT] <= 1'b1;
            end else if (bus.csr_we && bus.csr_addr == CSR_MSTATUS) begin
                mstatus_q <= bus.csr_wdata & MSTATUS_MASK;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_req_q <= 1'b0;
            cause_q    <= '0;
        end else begin
            trap_req_q <= (state_d == REQ);
            if (take)
                cause_q <= irq_cause(pend);
        end
    end

    assign bus.trap_req   = trap_req_q;
    assign bus.trap_cause = cause_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: CSR access, trap
// handshake, priority, sync latency and reset.
module tb_irq_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic irq_timer;
    logic irq_sw;
    logic irq_ext;
    int   checks   = 0;
    int   failures = 0;

    irq_ctrl_if bus ();

    irq_ctrl #(.SYNC_EXT(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_timer (irq_timer),
        .irq_sw    (irq_sw),
        .irq_ext   (irq_ext),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        bus.csr_addr = a;
        #1;
        d = bus.csr_rdata;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.csr_we    = 1'b1;
        bus.csr_addr  = a;
        bus.csr_wdata = d;
        @(negedge clk);
        bus.csr_we    = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.trap_ack = 1'b1;
        @(negedge clk);
        bus.trap_ack = 1'b0;
    endtask

    task automatic pulse_mret();
        bus.mret = 1'b1;
        @(negedge clk);
        bus.mret = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        irq_timer = 0; irq_sw = 0; irq_ext = 0;
        bus.csr_we = 0; bus.csr_addr = '0; bus.csr_wdata = '0;
        bus.trap_ack = 0; bus.mret = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.trap_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_trap_req got %b exp 0", bus.trap_req);
        end
        checks++;
        if (bus.trap_cause !== 32'h0) begin
            failures++;
            $display("FAIL reset_cause got %h exp 0", bus.trap_cause);
        end
        rd(12'h300, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL reset_mstatus got %h exp 0", d);
        end
        rd(12'h304, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL reset_mie got %h exp 0", d);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_csr();
        logic [31:0] d;
        wr(12'h304, 32'hFFFF_FFFF);
        rd(12'h304, d);
        checks++;
        if (d !== 32'h0000_0888) begin
            failures++;
            $display("FAIL csr_mie_mask got %h exp 00000888", d);
        end
        wr(12'h300, 32'hFFFF_FFFF);
        rd(12'h300, d);
        checks++;
        if (d !== 32'h0000_0088) begin
            failures++;
            $display("FAIL csr_mstatus_mask got %h exp 00000088", d);
        end
        wr(12'h344, 32'hFFFF_FFFF);
        rd(12'h344, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL csr_mip_ro got %h exp 0", d);
        end
        wr(12'h123, 32'hFFFF_FFFF);
        rd(12'h123, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL csr_unimpl got %h exp 0", d);
        end
        checks++;
        if (bus.trap_req !== 1'b0) begin
            failures++;
            $display("FAIL csr_no_req got %b exp 0", bus.trap_req);
        end
        wr(12'h300, 32'h0);
        wr(12'h304, 32'h0);
    endtask

    task automatic test_mip();
        logic [31:0] d;
        @(negedge clk);
        irq_sw = 1; irq_timer = 1; irq_ext = 1;
        rd(12'h344, d);
        checks++;
        if (d !== 32'h0000_0088) begin
            failures++;
            $display("FAIL mip_sync_src got %h exp 00000088", d);
        end
        @(negedge clk);
        rd(12'h344, d);
        checks++;
        if (d !== 32'h0000_0088) begin
            failures++;
            $display("FAIL mip_ext_1cyc got %h exp 00000088", d);
        end
        @(negedge clk);
        rd(12'h344, d);
        checks++;
        if (d !== 32'h0000_0888) begin
            failures++;
            $display("FAIL mip_ext_2cyc got %h exp 00000888", d);
        end
        irq_sw = 0; irq_timer = 0; irq_ext = 0;
        repeat (3) @(negedge clk);
        rd(12'h344, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL mip_clear got %h exp 0", d);
        end
    endtask

    task automatic test_timer();
        logic [31:0] d;
        wr(12'h304, 32'h80);
        wr(12'h300, 32'h8);
        irq_timer = 1;
        #1;
        checks++;
        if (bus.trap_req !== 1'b0) begin
            failures++;
            $display("FAIL timer_early got %b exp 0", bus.trap_req);
        end
        @(negedge clk);
        checks++;
        if (bus.trap_req !== 1'b1 || bus.trap_cause !== 32'h8000_0007) begin
            failures++;
            $display("FAIL timer_req got %b/%h exp 1/80000007",
                     bus.trap_req, bus.trap_cause);
        end
        irq_timer = 0;
        wr(12'h300, 32'h0);
        rd(12'h300, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL hold_mstatus got %h exp 0", d);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.trap_req !== 1'b1 || bus.trap_cause !== 32'h8000_0007) begin
            failures++;
            $display("FAIL hold_req got %b/%h exp 1/80000007",
                     bus.trap_req, bus.trap_cause);
        end
        pulse_ack();
        checks++;
        if (bus.trap_req !== 1'b0) begin
            failures++;
            $display("FAIL hold_ack_req got %b exp 0", bus.trap_req);
        end
        rd(12'h300, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL hold_ack_mstatus got %h exp 0", d);
        end
        pulse_mret();
        rd(12'h300, d);
        checks++;
        if (d !== 32'h80) begin
            failures++;
            $display("FAIL hold_mret_mstatus got %h exp 80", d);
        end
        wr(12'h300, 32'h0);
    endtask

    task automatic test_ack_mret();
        logic [31:0] d;
        wr(12'h304, 32'h80);
        wr(12'h300, 32'h8);
        pulse_ack();
        rd(12'h300, d);
        checks++;
        if (d !== 32'h8) begin
            failures++;
            $display("FAIL idle_ack_ignored got %h exp 8", d);
        end
        irq_timer = 1;
        @(negedge clk);
        checks++;
        if (bus.trap_req !== 1'b1) begin
            failures++;
            $display("FAIL am_req got %b exp 1", bus.trap_req);
        end
        irq_timer = 0;
        pulse_ack();
        rd(12'h300, d);
        checks++;
        if (d !== 32'h80 || bus.trap_req !== 1'b0) begin
            failures++;
            $display("FAIL am_ack got %h/%b exp 80/0", d, bus.trap_req);
        end
        pulse_mret();
        rd(12'h300, d);
        checks++;
        if (d !== 32'h88) begin
            failures++;
            $display("FAIL am_mret got %h exp 88", d);
        end
        irq_timer = 1;
        @(negedge clk);
        checks++;
        if (bus.trap_req !== 1'b1) begin
            failures++;
            $display("FAIL am_idle_again got %b exp 1", bus.trap_req);
        end
        irq_timer = 0;
        pulse_ack();
        pulse_mret();
    endtask

    task automatic test_ack_write();
        logic [31:0] d;
        irq_timer = 1;
        @(negedge clk);
        pulse_mret();
        rd(12'h300, d);
        checks++;
        if (bus.trap_req !== 1'b1 || d !== 32'h88) begin
            failures++;
            $display("FAIL req_mret_ignored got %b/%h exp 1/88",
                     bus.trap_req, d);
        end
        irq_timer     = 0;
        bus.trap_ack  = 1;
        bus.csr_we    = 1;
        bus.csr_addr  = 12'h300;
        bus.csr_wdata = 32'h8;
        @(negedge clk);
        bus.trap_ack  = 0;
        bus.csr_we    = 0;
        rd(12'h300, d);
        checks++;
        if (d !== 32'h80) begin
            failures++;
            $display("FAIL ack_write got %h exp 80", d);
        end
        pulse_mret();
        wr(12'h300, 32'h80);
        pulse_mret();
        rd(12'h300, d);
        checks++;
        if (d !== 32'h88) begin
            failures++;
            $display("FAIL idle_mret got %h exp 88", d);
        end
        wr(12'h300, 32'h0);
        wr(12'h304, 32'h0);
    endtask

    task automatic test_ext_latency();
        wr(12'h304, 32'h800);
        wr(12'h300, 32'h8);
        irq_ext = 1;
        @(negedge clk);
        checks++;
        if (bus.trap_req !== 1'b0) begin
            failures++;
            $display("FAIL ext_cyc1 got %b exp 0", bus.trap_req);
        end
        @(negedge clk);
        checks++;
        if (bus.trap_req !== 1'b0) begin
            failures++;
            $display("FAIL ext_cyc2 got %b exp 0", bus.trap_req);
        end
        @(negedge clk);
        checks++;
        if (bus.trap_req !== 1'b1 || bus.trap_cause !== 32'h8000_000B) begin
            failures++;
            $display("FAIL ext_cyc3 got %b/%h exp 1/8000000b",
                     bus.trap_req, bus.trap_cause);
        end
        irq_ext = 0;
        pulse_ack();
        pulse_mret();
        wr(12'h300, 32'h0);
        wr(12'h304, 32'h0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_priority();
        wr(12'h304, 32'h888);
        wr(12'h300, 32'h8);
        irq_sw = 1; irq_timer = 1; irq_ext = 1;
        @(negedge clk);
        checks++;
        if (bus.trap_req !== 1'b1 || bus.trap_cause !== 32'h8000_0003) begin
            failures++;
            $display("FAIL prio_first got %b/%h exp 1/80000003",
                     bus.trap_req, bus.trap_cause);
        end
        pulse_ack();
        pulse_mret();
        checks++;
        if (bus.trap_req !== 1'b0) begin
            failures++;
            $display("FAIL prio_gap got %b exp 0", bus.trap_req);
        end
        @(negedge clk);
        checks++;
        if (bus.trap_req !== 1'b1 || bus.trap_cause !== 32'h8000_000B) begin
            failures++;
            $display("FAIL prio_second got %b/%h exp 1/8000000b",
                     bus.trap_req, bus.trap_cause);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        #2;
        rst = 1;
        #1;
        checks++;
        if (bus.trap_req !== 1'b0 || bus.trap_cause !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid got %b/%h exp 0/0",
                     bus.trap_req, bus.trap_cause);
        end
        @(negedge clk);
        rst = 0;
        rd(12'h300, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL rst_mstatus got %h exp 0", d);
        end
        rd(12'h304, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL rst_mie got %h exp 0", d);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.trap_req !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_req got %b exp 0", bus.trap_req);
        end
        irq_sw = 0; irq_timer = 0; irq_ext = 0;
    endtask

    initial begin
        test_reset();
        test_csr();
        test_mip();
        test_timer();
        test_ack_mret();
        test_ack_write();
        test_ext_latency();
        test_priority();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter SYNC_EXT, default 1, 1 = pass irq_ext through a 2-flop synchronizer, 0 = use irq_ext directly.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 irq_timer  input  1  machine timer interrupt level from the timer block; synchronous to clk.
REQ-005 irq_sw  input  1  machine software interrupt level from the timer block; synchronous to clk.
REQ-006 irq_ext  input  1  external interrupt level; asynchronous when SYNC_EXT=1.
REQ-007 csr_we  input  1  CSR write strobe, one write per cycle.
REQ-008 csr_addr  input  12  CSR address for read and write.
REQ-009 csr_wdata  input  32  CSR write data.
REQ-010 csr_rdata  output  32  CSR read data, combinational from csr_addr.
REQ-011 trap_req  output  1  interrupt trap request to core, registered.
REQ-012 trap_cause  output  32  mcause value for the pending request, registered.
REQ-013 trap_ack  input  1  core accepts trap this cycle.
REQ-014 mret  input  1  core retires MRET this cycle.

Function
REQ-015 Implemented CSRs: mstatus 0x300 (MIE bit 3, MPIE bit 7), mie 0x304 (MSIE 3, MTIE 7, MEIE 11), mip 0x344 (MSIP 3, MTIP 7, MEIP 11). All other bits read 0.
REQ-016 mip is read-only; it reflects irq_sw, irq_timer, and the synchronized irq_ext; writes to 0x344 are ignored.
REQ-017 A read of an unimplemented address returns 32'h0. A write to an unimplemented address has no effect.
REQ-018 A CSR write updates only the implemented bits and is visible on csr_rdata the cycle after csr_we.
REQ-019 pending = mip & mie; an interrupt is eligible when mstatus.MIE=1 and pending!=0.
REQ-020 Priority: MEI (code 11) > MSI (code 3) > MTI (code 7).
REQ-021 trap_cause = 32'h8000_0000 | code.
REQ-022 FSM states IDLE, REQ, TRAP; the state register resets to IDLE.
REQ-023 IDLE -> REQ on the cycle after eligibility. trap_cause is latched at this transition.
REQ-024 Latency: trap_req rises 1 cycle after a synchronous source is eligible; with SYNC_EXT=1, irq_ext adds 2 cycles.
REQ-025 In REQ, trap_req=1 and trap_cause is held stable until trap_ack, even if the source deasserts.
REQ-026 REQ -> TRAP on trap_ack. In the same edge, MPIE<=MIE and MIE<=0.
REQ-027 TRAP -> IDLE on mret. In the same edge, MIE<=MPIE and MPIE<=1.
REQ-028 mret in IDLE performs the same MIE/MPIE restore and leaves the state at IDLE. mret in REQ is ignored.
REQ-029 trap_ack outside REQ is ignored.
REQ-030 When a write to mstatus coincides with trap_ack or mret, the FSM update of MIE/MPIE wins.
REQ-031 A write that clears MIE or mie bits while in REQ does not withdraw the request.
REQ-032 trap_req=0 in IDLE and TRAP.

Reset
REQ-033 When rst is asserted, state=IDLE, trap_req=0, trap_cause=0, mstatus=0, mie=0, and the synchronizer flops=0, all immediately and asynchronously.
REQ-034 Reset mid-REQ drops trap_req in the same cycle. No request is issued until rst is low and eligibility is re-evaluated.

Structure
REQ-035 Shared package irq_pkg holds the CSR address constants, the bit positions (MIE, MPIE, MSI, MTI, MEI), the cause codes, and the FSM state enum.
REQ-036 One sub-module, sync2: a 2-flop synchronizer with async active-high reset, instantiated for irq_ext when SYNC_EXT=1.

Verification
REQ-037 Write mie=0x80 and mstatus=0x8, then raise irq_timer -> trap_req=1 one cycle later with trap_cause=0x8000_0007.
REQ-038 Set all three enables and raise irq_sw, irq_timer and irq_ext together (SYNC_EXT=1) -> first trap_cause=0x8000_0003 at +1 cycle. After ack and mret, the next request is trap_cause=0x8000_000B.
REQ-039 In REQ, deassert irq_timer and write mstatus=0 -> trap_req stays 1 with the same cause until trap_ack. After ack, mstatus reads 0x0.
REQ-040 From the trap_ack edge, read mstatus -> 0x80. Pulse mret -> mstatus reads 0x88 and the state returns to IDLE.
REQ-041 Write mstatus=0x8 in the same cycle as trap_ack -> mstatus reads 0x80 (the FSM update wins).
REQ-042 Assert rst while trap_req=1 -> trap_req=0 in the same cycle, and all CSRs read 0 after rst is released.
